tlb_ctrl: RTL and testbench

TLB_CTRL -- requirements
Module: tlb_ctrl

---
 rtl/tlb_ctrl_if.sv | 34 +++
 rtl/tlb_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ctrl_if.sv
// TLB maintenance operation request bundle.
// The master issues TLBWI/TLBWR/TLBP/TLBR together with the CP0 operands.
interface tlb_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [3:0]  index_i;
  logic [31:0] entryhi_i;
  logic [31:0] entrylo0_i;
  logic [31:0] entrylo1_i;
  logic [3:0]  wired_i;

  modport master (
    output op_valid,
    output op_code,
    output index_i,
    output entryhi_i,
    output entrylo0_i,
    output entrylo1_i,
    output wired_i,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  index_i,
    input  entryhi_i,
    input  entrylo0_i,
    input  entrylo1_i,
    input  wired_i,
    output op_ready
  );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB maintenance controller: TLBWI/TLBWR writes, TLBP linear probe,
// TLBR readback from a shadow copy, plus the CP0 Random counter.
module tlb_ctrl #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  tlb_ctrl_if.slave   op,
  output logic        tlb_we,
  output logic [3:0]  tlb_index,
  output logic [62:0] tlb_data,
  output logic        done,
  output logic        probe_hit,
  output logic [3:0]  probe_index,
  output logic [31:0] rd_entryhi,
  output logic [31:0] rd_entrylo0,
  output logic [31:0] rd_entrylo1,
  output logic [3:0]  random_o
);

  localparam logic [3:0] LAST = 4'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PROBE,
    READ
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [62:0] shadow [ENTRIES];
  logic [3:0]  scan;
  logic [62:0] cur;
  logic [62:0] rd_sel;
  logic        match;
  logic        probe_fin;
  logic        accept;
  logic [62:0] pack;

  logic        hit_q;
  logic [3:0]  pidx_q;
  logic [31:0] rhi_q;
  logic [31:0] rlo0_q;
  logic [31:0] rlo1_q;
  logic [31:0] rhi_c;
  logic [31:0] rlo0_c;
  logic [31:0] rlo1_c;

  logic is_wr;
  logic is_probe;
  logic is_read;

  assign is_wr    = ~op.op_code[1];
  assign is_probe = op.op_code == 2'b10;
  assign is_read  = op.op_code == 2'b11;

  assign op.op_ready = state == IDLE;
  assign accept      = op.op_ready & op.op_valid;

  assign pack = {
    op.entryhi_i[31:13],
    op.entrylo1_i[25:6],
    op.entrylo1_i[2],
    op.entrylo1_i[1],
    op.entrylo0_i[25:6],
    op.entrylo0_i[2],
    op.entrylo0_i[1]
  };

  // VPN2 of the latched request lives in tlb_data[62:44]
  assign cur   = shadow[scan];
  assign match = cur[62:44] == tlb_data[62:44];

  assign rd_sel = shadow[tlb_index];
  assign rhi_c  = {rd_sel[62:44], 13'b0};
  assign rlo1_c = {6'b0, rd_sel[43:24], 3'b0,
                   rd_sel[23], rd_sel[22], 1'b0};
  assign rlo0_c = {6'b0, rd_sel[21:2], 3'b0,
                   rd_sel[1], rd_sel[0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (op.op_valid) begin
          unique case (1'b1)
            is_wr:    state_nxt = WRITE;
            is_probe: state_nxt = PROBE;
            is_read:  state_nxt = READ;
          endcase
        end
      end
      WRITE: state_nxt = IDLE;
      READ:  state_nxt = IDLE;
      PROBE: begin
        if (match || scan == LAST)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    probe_fin   = (state == PROBE) &
                  (match | (scan == LAST));
    tlb_we      = state == WRITE;
    done        = tlb_we | probe_fin |
                  (state == READ);
    probe_hit   = hit_q;
    probe_index = pidx_q;
    if (probe_fin) begin
      probe_hit   = match;
      probe_index = match ? scan : 4'd0;
    end
    rd_entryhi  = rhi_q;
    rd_entrylo0 = rlo0_q;
    rd_entrylo1 = rlo1_q;
    if (state == READ) begin
      rd_entryhi  = rhi_c;
      rd_entrylo0 = rlo0_c;
      rd_entrylo1 = rlo1_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlb_index <= '0;
      tlb_data  <= '0;
      scan      <= '0;
    end else if (accept) begin
      tlb_index <= (op.op_code == 2'b01) ?
                   random_o : op.index_i;
      tlb_data  <= pack;
      scan      <= '0;
    end else if (state == PROBE) begin
      scan <= scan + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++)
        shadow[i] <= '0;
    end else if (tlb_we) begin
      shadow[tlb_index] <= tlb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= 1'b0;
      pidx_q <= '0;
      rhi_q  <= '0;
      rlo0_q <= '0;
      rlo1_q <= '0;
    end else begin
      if (probe_fin) begin
        hit_q  <= probe_hit;
        pidx_q <= probe_index;
      end
      if (state == READ) begin
        rhi_q  <= rhi_c;
        rlo0_q <= rlo0_c;
        rlo1_q <= rlo1_c;
      end
    end
  end

  // Wraps to 15 at or below Wired, so Wired=15 pins it at 15
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      random_o <= 4'hF;
    else if (random_o <= op.wired_i)
      random_o <= 4'hF;
    else
      random_o <= random_o - 4'd1;
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: table of TLB operations plus
// hand sequences for reset, Random and TLBWR.
module tb_tlb_ctrl;

  logic        clk;
  logic        rst;
  logic        tlb_we;
  logic [3:0]  tlb_index;
  logic [62:0] tlb_data;
  logic        done;
  logic        probe_hit;
  logic [3:0]  probe_index;
  logic [31:0] rd_entryhi;
  logic [31:0] rd_entrylo0;
  logic [31:0] rd_entrylo1;
  logic [3:0]  random_o;

  int errors;
  int checks;

  tlb_ctrl_if ifc ();

  tlb_ctrl #(.ENTRIES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (ifc.slave),
    .tlb_we      (tlb_we),
    .tlb_index   (tlb_index),
    .tlb_data    (tlb_data),
    .done        (done),
    .probe_hit   (probe_hit),
    .probe_index (probe_index),
    .rd_entryhi  (rd_entryhi),
    .rd_entrylo0 (rd_entrylo0),
    .rd_entrylo1 (rd_entrylo1),
    .random_o    (random_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
    int          lat;
    logic [3:0]  eidx;
    logic [62:0] data;
    logic        hit;
    logic [31:0] rhi;
    logic [31:0] rlo0;
    logic [31:0] rlo1;
  } vec_t;

  vec_t tbl [12];
  vec_t v;
  logic [3:0] seq [4];
  int we_seen;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    ifc.op_code    = x.op;
    ifc.index_i    = x.idx;
    ifc.entryhi_i  = x.hi;
    ifc.entrylo0_i = x.lo0;
    ifc.entrylo1_i = x.lo1;
    ifc.op_valid   = 1'b1;
  endtask

  task automatic run_vec(input vec_t x);
    int n;
    @(negedge clk);
    chk("ready", {63'b0, ifc.op_ready}, 64'd1);
    drive(x);
    @(negedge clk);
    ifc.op_valid = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done", {63'b0, done}, 64'd1);
    chk("latency", 64'(n), 64'(x.lat));
    case (x.op)
      2'b00, 2'b01: begin
        chk("tlb_we", {63'b0, tlb_we}, 64'd1);
        chk("tlb_index", 64'(tlb_index), 64'(x.eidx));
        chk("tlb_data", 64'(tlb_data), 64'(x.data));
      end
      2'b10: begin
        chk("probe_hit", {63'b0, probe_hit}, {63'b0, x.hit});
        chk("probe_index", 64'(probe_index), 64'(x.eidx));
      end
      default: begin
        chk("rd_entryhi", 64'(rd_entryhi), 64'(x.rhi));
        chk("rd_entrylo0", 64'(rd_entrylo0), 64'(x.rlo0));
        chk("rd_entrylo1", 64'(rd_entrylo1), 64'(x.rlo1));
      end
    endcase
    @(negedge clk);
    chk("done_clr", {63'b0, done}, 64'd0);
    chk("we_clr", {63'b0, tlb_we}, 64'd0);
    if (x.op == 2'b10) begin
      chk("hit_hold", {63'b0, probe_hit}, {63'b0, x.hit});
      chk("pidx_hold", 64'(probe_index), 64'(x.eidx));
    end
    if (x.op == 2'b11)
      chk("rdhi_hold", 64'(rd_entryhi), 64'(x.rhi));
  endtask

  task automatic chk_reset();
    chk("rst_we", {63'b0, tlb_we}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hit", {63'b0, probe_hit}, 64'd0);
    chk("rst_pidx", 64'(probe_index), 64'd0);
    chk("rst_index", 64'(tlb_index), 64'd0);
    chk("rst_data", 64'(tlb_data), 64'd0);
    chk("rst_rdhi", 64'(rd_entryhi), 64'd0);
    chk("rst_rdlo0", 64'(rd_entrylo0), 64'd0);
    chk("rst_rdlo1", 64'(rd_entrylo1), 64'd0);
    chk("rst_random", 64'(random_o), 64'hF);
    chk("rst_ready", {63'b0, ifc.op_ready}, 64'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    seq = '{4'd15, 4'd14, 4'd13, 4'd12};

    tbl[0]  = '{2'd2, 4'd0, 32'h0, 32'h0, 32'h0, 1, 4'd0,
                63'h0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{2'd0, 4'd5, 32'h00402000, 32'h46, 32'h87, 1, 4'd5,
                {19'h00201, 20'h2, 1'b1, 1'b1, 20'h1, 1'b1, 1'b1},
                1'b0, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{2'd2, 4'd0, 32'h00402000, 32'h0, 32'h0, 6, 4'd5,
                63'h0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{2'd0, 4'd0, 32'hFFFFE000, 32'h0, 32'h0, 1, 4'd0,
                {19'h7FFFF, 44'h0}, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[4]  = tbl[2];
    tbl[5]  = '{2'd2, 4'd0, 32'h2468A000, 32'h0, 32'h0, 16, 4'd0,
                63'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[6]  = '{2'd3, 4'd5, 32'h0, 32'h0, 32'h0, 1, 4'd0,
                63'h0, 1'b0, 32'h00402000, 32'h46, 32'h86};
    tbl[7]  = '{2'd2, 4'd0, 32'h0, 32'h0, 32'h0, 2, 4'd1,
                63'h0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{2'd3, 4'd0, 32'h0, 32'h0, 32'h0, 1, 4'd0,
                63'h0, 1'b0, 32'hFFFFE000, 32'h0, 32'h0};
    tbl[9]  = '{2'd0, 4'd15, 32'h2468A000, 32'hFFFFFFFF, 32'h0, 1,
                4'd15,
                {19'h12345, 20'h0, 1'b0, 1'b0, 20'hFFFFF, 1'b1, 1'b1},
                1'b0, 32'h0, 32'h0, 32'h0};
    tbl[10] = '{2'd2, 4'd0, 32'h2468A000, 32'h0, 32'h0, 16, 4'd15,
                63'h0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[11] = '{2'd3, 4'd15, 32'h0, 32'h0, 32'h0, 1, 4'd0,
                63'h0, 1'b0, 32'h2468A000, 32'h03FFFFC6, 32'h0};

    rst            = 1'b0;
    ifc.op_valid   = 1'b0;
    ifc.op_code    = 2'b00;
    ifc.index_i    = 4'd0;
    ifc.entryhi_i  = 32'h0;
    ifc.entrylo0_i = 32'h0;
    ifc.entrylo1_i = 32'h0;
    ifc.wired_i    = 4'd0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_vec(tbl[i]);

    // reset in the middle of a long probe
    @(negedge clk);
    drive(tbl[5]);
    @(negedge clk);
    ifc.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_ready", {63'b0, ifc.op_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tlb_we) we_seen++;
    end
    chk("no_we_after_rst", 64'(we_seen), 64'd0);

    v = tbl[2];
    v.lat  = 16;
    v.hit  = 1'b0;
    v.eidx = 4'd0;
    run_vec(v);

    // Random sequence with Wired=12, then TLBWR
    @(negedge clk);
    rst = 1'b0;
    ifc.wired_i = 4'd12;
    @(negedge clk);
    rst = 1'b1;
    chk("rand0", 64'(random_o), 64'hF);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("rand_seq", 64'(random_o), 64'(seq[i % 4]));
    end
    v = tbl[1];
    v.op  = 2'b01;
    v.idx = 4'd2;
    drive(v);
    @(negedge clk);
    ifc.op_valid = 1'b0;
    chk("wr_we", {63'b0, tlb_we}, 64'd1);
    chk("wr_done", {63'b0, done}, 64'd1);
    chk("wr_index", 64'(tlb_index), 64'd13);
    chk("wr_data", 64'(tlb_data), 64'(tbl[1].data));
    chk("wr_rand", 64'(random_o), 64'd12);

    v = tbl[6];
    v.idx = 4'd13;
    run_vec(v);

    @(negedge clk);
    ifc.wired_i = 4'd15;
    @(negedge clk);
    chk("wired15_a", 64'(random_o), 64'hF);
    repeat (3) @(negedge clk);
    chk("wired15_b", 64'(random_o), 64'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
